// File: rtl/compound_sink_accumulator_if.sv
// compound_sink_accumulator_if: command stream type plus the command/result handshake bundle.
package compound_pkg;
  localparam logic MODE_WR = 1'b0;
  localparam logic MODE_RD = 1'b1;
  typedef struct packed {
    logic mode;
    logic signed [31:0] x;
    logic y;
  } compound_t;
endpackage

interface compound_sink_accumulator_if #(parameter int ACC_W = 32);
  compound_pkg::compound_t b_in;
  logic b_in_sync;
  logic b_in_notify;
  logic [ACC_W-1:0] res_out;
  logic res_out_sync;
  logic res_out_notify;
  logic err_out;
  modport master (output b_in, b_in_sync, res_out_sync, input b_in_notify, res_out, res_out_notify, err_out);
  modport slave (input b_in, b_in_sync, res_out_sync, output b_in_notify, res_out, res_out_notify, err_out);
endinterface

// File: rtl/compound_sink_accumulator.sv
// compound_sink_accumulator: FIFO-buffered command sink that accumulates writes and publishes the sum on reads.
module compound_sink_accumulator
  import compound_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ACC_W = 32
) (
  input logic clk,
  input logic rst,
  compound_sink_accumulator_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, EMIT = 2'd2;
  compound_t mem [DEPTH];
  compound_t cmd_q;
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic [1:0] state;
  logic [ACC_W-1:0] acc, xs, sum;
  logic push, pop, ovf;
  assign bus.b_in_notify = count != FULL;
  assign push = bus.b_in_sync && bus.b_in_notify;
  assign pop = state == IDLE && count != '0;
  assign xs = ACC_W'($signed(cmd_q.x));
  assign sum = cmd_q.y ? acc - xs : acc + xs;
  // Add overflows when operands share a sign the result lacks; subtract when they differ.
  assign ovf = (cmd_q.y ? acc[ACC_W-1] != xs[ACC_W-1] : acc[ACC_W-1] == xs[ACC_W-1]) && sum[ACC_W-1] != acc[ACC_W-1];
  always_ff @(posedge clk)
    if (push) mem[wp] <= bus.b_in;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      state <= IDLE;
      cmd_q <= '0;
      acc <= '0;
      bus.res_out <= '0;
      bus.res_out_notify <= 1'b0;
      bus.err_out <= 1'b0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      case (state)
        IDLE: if (pop) begin
          cmd_q <= mem[rp];
          state <= EXEC;
        end
        EXEC: if (cmd_q.mode == MODE_RD) begin
          bus.res_out <= acc;
          bus.res_out_notify <= 1'b1;
          state <= EMIT;
        end else begin
          acc <= sum;
          if (ovf) bus.err_out <= 1'b1;
          state <= IDLE;
        end
        EMIT: if (bus.res_out_sync) begin
          bus.res_out_notify <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_compound_sink_accumulator.sv
// tb_compound_sink_accumulator: directed stimulus with a result scoreboard drained by an independent monitor.
module tb_compound_sink_accumulator;
  import compound_pkg::*;
  typedef struct {
    logic [31:0] res;
    logic err;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  exp_t q[$];
  compound_sink_accumulator_if #(.ACC_W(32)) bus ();
  compound_sink_accumulator #(.DEPTH(4), .ACC_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic mode, input logic [31:0] x, input logic y);
    int n = 0;
    bus.b_in = '{mode: mode, x: x, y: y};
    bus.b_in_sync = 1'b1;
    while (!bus.b_in_notify && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) check("push_timeout", 32'd0, 32'd1);
    tick();
    bus.b_in_sync = 1'b0;
  endtask

  task automatic wr(input logic [31:0] x, input logic y);
    push(MODE_WR, x, y);
  endtask

  task automatic rd(input logic [31:0] res, input logic err);
    q.push_back('{res: res, err: err});
    push(MODE_RD, 32'd0, 1'b0);
  endtask

  task automatic wait_notify();
    int n = 0;
    while (!bus.res_out_notify && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) check("notify_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || bus.res_out_notify) && n < 200) begin
      tick();
      n++;
    end
    if (n == 200) check("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.res_out_notify && bus.res_out_sync) begin
        if (q.size() == 0) check("unexpected_result", bus.res_out, 32'hxxxxxxxx);
        else begin
          e = q.pop_front();
          check("res_out", bus.res_out, e.res);
          check("err_out", 32'(bus.err_out), 32'(e.err));
        end
      end
    end
  end

  initial begin
    bus.b_in = '0;
    bus.b_in_sync = 1'b0;
    bus.res_out_sync = 1'b1;
    repeat (2) tick();
    check("rst_b_in_notify", 32'(bus.b_in_notify), 32'd1);
    check("rst_res_out_notify", 32'(bus.res_out_notify), 32'd0);
    check("rst_err_out", 32'(bus.err_out), 32'd0);
    check("rst_res_out", bus.res_out, 32'd0);
    rst = 1'b0;
    tick();
    // read of an empty accumulator: pushed at edge N, result visible after N+2
    q.push_back('{res: 32'd0, err: 1'b0});
    bus.b_in = '{mode: MODE_RD, x: 32'd0, y: 1'b0};
    bus.b_in_sync = 1'b1;
    tick();
    bus.b_in_sync = 1'b0;
    tick();
    check("lat_n1_notify", 32'(bus.res_out_notify), 32'd0);
    tick();
    check("lat_n2_notify", 32'(bus.res_out_notify), 32'd1);
    tick();
    check("lat_cleared", 32'(bus.res_out_notify), 32'd0);
    drain();
    wr(32'd5, 1'b0);
    wr(32'd3, 1'b1);
    rd(32'd2, 1'b0);
    drain();
    bus.res_out_sync = 1'b0;
    rd(32'd2, 1'b0);
    wait_notify();
    for (int i = 1; i <= 4; i++) wr(32'(i), 1'b0);
    check("bp_full_notify", 32'(bus.b_in_notify), 32'd0);
    bus.b_in = '{mode: MODE_WR, x: 32'd100, y: 1'b0};
    bus.b_in_sync = 1'b1;
    repeat (3) tick();
    check("bp_still_full", 32'(bus.b_in_notify), 32'd0);
    bus.b_in_sync = 1'b0;
    bus.res_out_sync = 1'b1;
    rd(32'd12, 1'b0);
    drain();
    bus.res_out_sync = 1'b0;
    rd(32'd12, 1'b0);
    wait_notify();
    for (int i = 0; i < 4; i++) wr(32'd1, 1'b0);
    bus.b_in = '{mode: MODE_WR, x: 32'd10, y: 1'b0};
    bus.b_in_sync = 1'b1;
    bus.res_out_sync = 1'b1;
    tick();
    check("sim_e1_notify", 32'(bus.b_in_notify), 32'd0);
    tick();
    check("sim_e2_no_push", 32'(bus.b_in_notify), 32'd1);
    tick();
    check("sim_e3_pushed", 32'(bus.b_in_notify), 32'd0);
    bus.b_in_sync = 1'b0;
    rd(32'd26, 1'b0);
    drain();
    bus.res_out_sync = 1'b0;
    push(MODE_RD, 32'd0, 1'b0);
    wr(32'd7, 1'b0);
    wait_notify();
    check("emit_notify", 32'(bus.res_out_notify), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_notify", 32'(bus.res_out_notify), 32'd0);
    check("mid_rst_res_out", bus.res_out, 32'd0);
    check("mid_rst_b_in_notify", 32'(bus.b_in_notify), 32'd1);
    tick();
    rst = 1'b0;
    bus.res_out_sync = 1'b1;
    rd(32'd0, 1'b0);
    drain();
    wr(32'h7fffffff, 1'b0);
    wr(32'd1, 1'b0);
    rd(32'h80000000, 1'b1);
    wr(32'd1, 1'b1);
    rd(32'h7fffffff, 1'b1);
    wr(32'd4, 1'b0);
    rd(32'h80000003, 1'b1);
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
